load_store_unit: RTL and testbench

Core-side initiator for the data port of the memory controller. It accepts one load or store at a time from the execute stage, checks alignment, and drives the `mem_*` request/ready handshake. The controller always moves whole 64-bit words, so this block does the byte-lane work itself:
- loads fetch the containing doubleword, then shift and sign/zero-extend it;
- sub-doubleword stores are done as read-modify-write (read, merge, write back).

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Core-side load/store initiator: one operation at a time over a 64-bit word port.
// Loads extract and extend byte lanes; sub-doubleword stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_read_req,
    output logic            mem_write_req,
    output logic [2:0]      mem_size,
    output logic            mem_signed,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic            mem_error
);

    typedef enum logic [2:0] {StIdle, StLd, StRmwRd, StRmwWr, StStWr, StResp} state_e;

    state_e          state_q;
    logic [XLEN-1:0] rbuf;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      addr_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic            store_q;
    logic            misaligned;
    logic [5:0]      sh;
    logic [XLEN-1:0] bmask;

    // Size 3 shifts by 64, which yields an all-ones mask after inversion.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        return ~({XLEN{1'b1}} << (7'd8 << sz));
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                               input logic sg);
        case (sz)
            2'd0:    return {{(XLEN-8){sg & d[7]}}, d[7:0]};
            2'd1:    return {{(XLEN-16){sg & d[15]}}, d[15:0]};
            2'd2:    return {{(XLEN-32){sg & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = req_addr[0];
            3'd2:    misaligned = |req_addr[1:0];
            3'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign sh         = {addr_q, 3'b000};
    assign bmask      = size_mask(size_q) << sh;
    assign req_ready  = (state_q == StIdle);
    assign mem_size   = 3'd3;
    assign mem_signed = 1'b0;
    // Data is only meaningful in the response cycle of a successful load.
    assign resp_rdata = (state_q == StResp && !resp_error && !store_q)
                        ? extend(rbuf >> sh, size_q, signed_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rbuf          <= '0;
            wdata_q       <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            store_q       <= 1'b0;
            resp_valid    <= 1'b0;
            resp_error    <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    resp_error <= 1'b0;
                    if (req_valid) begin
                        addr_q   <= req_addr[2:0];
                        size_q   <= req_size[1:0];
                        signed_q <= req_signed;
                        store_q  <= req_store;
                        wdata_q  <= req_wdata;
                        if (misaligned) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[XLEN-1:3], 3'b000};
                            if (!req_store) begin
                                state_q      <= StLd;
                                mem_read_req <= 1'b1;
                            end else if (req_size == 3'd3) begin
                                state_q       <= StStWr;
                                mem_write_req <= 1'b1;
                                mem_wdata     <= req_wdata;
                            end else begin
                                state_q      <= StRmwRd;
                                mem_read_req <= 1'b1;
                            end
                        end
                    end
                end
                StLd: begin
                    if (mem_ready) begin
                        mem_read_req <= 1'b0;
                        rbuf         <= mem_rdata;
                        state_q      <= StResp;
                        resp_valid   <= 1'b1;
                        resp_error   <= mem_error;
                    end
                end
                StRmwRd: begin
                    if (mem_ready) begin
                        mem_read_req <= 1'b0;
                        rbuf         <= mem_rdata;
                        if (mem_error) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            state_q       <= StRmwWr;
                            mem_write_req <= 1'b1;
                            mem_wdata     <= (mem_rdata & ~bmask) | ((wdata_q << sh) & bmask);
                        end
                    end
                end
                StRmwWr, StStWr: begin
                    if (mem_ready) begin
                        mem_write_req <= 1'b0;
                        state_q       <= StResp;
                        resp_valid    <= 1'b1;
                        resp_error    <= mem_error;
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_error <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a word-granular memory responder
// and a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [2:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read_req, mem_write_req, mem_signed, mem_ready, mem_error;
    logic [2:0]  mem_size;

    load_store_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Memory behind the controller, and the model's own view of memory.
    logic [63:0] phys    [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    int   stall = 0;
    int   age = 0;
    logic err_next = 1'b0;

    // Controller: ready arrives in the (2+stall)-th cycle a request is held.
    always @(negedge clk) begin
        if (!reset && (mem_read_req || mem_write_req)) begin
            age = age + 1;
            if (age >= 2 + stall) begin
                mem_ready = 1'b1;
                mem_error = err_next;
                mem_rdata = phys.exists(mem_addr >> 3) ? phys[mem_addr >> 3] : 64'h0;
                if (mem_write_req && !err_next) phys[mem_addr >> 3] = mem_wdata;
                err_next = 1'b0;
                age = 0;
            end else begin
                mem_ready = 1'b0;
                mem_error = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
            mem_error = 1'b0;
            age = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [63:0] a, input int sz);
        if (sz > 3) return 1'b1;
        return (a % (64'd1 << sz)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int sz, input logic sg);
        logic [63:0] w = ref_mem[a >> 3];
        int n = 1 << sz;
        int off = int'(a[2:0]);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (sg && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input int sz, input logic [63:0] wd);
        logic [63:0] w = ref_mem[a >> 3];
        int off = int'(a[2:0]);
        for (int i = 0; i < (1 << sz); i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        ref_mem[a >> 3] = w;
    endtask

    function automatic int exp_lat(input logic st, input int sz, input logic [63:0] a,
                                   input int stl);
        if (is_mis(a, sz)) return 1;
        if (!st || sz == 3) return 3 + stl;
        return 5 + 2 * stl;
    endfunction

    // Results of the last operation.
    int          lat;
    logic [63:0] rd_mask, wr_mask, r_rdata, addr_seen, wdata_seen;
    logic        r_err, unstable, nodrop, rr_resp, resp_long;

    // Called at #1 into an idle cycle; returns at #1 into the idle cycle after RESP.
    task automatic do_op(input logic st, input logic [2:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd);
        logic prev_rd = 1'b0, prev_wr = 1'b0, first = 1'b1;
        logic [63:0] h_addr = '0, h_wdata = '0;
        lat = 0; rd_mask = '0; wr_mask = '0; r_rdata = '0; r_err = 1'b0;
        addr_seen = '0; wdata_seen = '0; unstable = 1'b0; nodrop = 1'b0;
        rr_resp = 1'b0; resp_long = 1'b0;
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c < 100; c++) begin
            if (mem_read_req && mem_write_req) unstable = 1'b1;
            if (mem_ready && ((prev_rd && mem_read_req) || (prev_wr && mem_write_req)))
                nodrop = 1'b1;
            if ((prev_rd || prev_wr) && !mem_ready) begin
                if (prev_rd !== mem_read_req || prev_wr !== mem_write_req ||
                    mem_addr !== h_addr || (mem_write_req && mem_wdata !== h_wdata))
                    unstable = 1'b1;
            end
            h_addr = mem_addr; h_wdata = mem_wdata;
            if ((mem_read_req || mem_write_req) && first) begin
                addr_seen = mem_addr;
                first = 1'b0;
            end
            if (mem_write_req) wdata_seen = mem_wdata;
            if (c < 64) begin
                rd_mask[c] = mem_read_req;
                wr_mask[c] = mem_write_req;
            end
            if (resp_valid) begin
                lat = c; r_rdata = resp_rdata; r_err = resp_error; rr_resp = req_ready;
                break;
            end
            prev_rd = mem_read_req; prev_wr = mem_write_req;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        resp_long = resp_valid;
    endtask

    initial begin
        logic        st, sg, seen;
        logic [2:0]  sz;
        logic [63:0] a, wd, er;
        int          el;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 3'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = '0;
        phys[64'h1000 >> 3] = 64'h8877_6655_4433_2211;
        phys[64'h2000 >> 3] = 64'h0;
        phys[64'h4000 >> 3] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 8; i++) phys[(64'h3000 >> 3) + 64'(i)] = {$urandom, $urandom};
        foreach (phys[k]) ref_mem[k] = phys[k];

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_mem_req", {62'd0, mem_read_req, mem_write_req}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("mem_size_const", {60'd0, mem_signed, mem_size}, 64'd3);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed loads from the preloaded word.
        do_op(1'b0, 3'd0, 1'b0, 64'h1003, 64'h0);
        check("lbu_data", r_rdata, 64'h44);
        check("lbu_lat", 64'(lat), 64'd3);
        check("lbu_addr", addr_seen, 64'h1000);
        check("resp_one_cycle", 64'(resp_long), 64'd0);
        check("ready_low_in_resp", 64'(rr_resp), 64'd0);
        do_op(1'b0, 3'd0, 1'b1, 64'h1007, 64'h0);
        check("lb_data", r_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        check("lb_lat", 64'(lat), 64'd3);
        check("lb_addr", addr_seen, 64'h1000);
        do_op(1'b0, 3'd1, 1'b0, 64'h1006, 64'h0);
        check("lhu_data", r_rdata, 64'h8877);
        check("lhu_lat", 64'(lat), 64'd3);
        check("lhu_addr", addr_seen, 64'h1000);
        do_op(1'b0, 3'd2, 1'b1, 64'h1004, 64'h0);
        check("lw_data", r_rdata, 64'hFFFF_FFFF_8877_6655);
        check("lw_lat", 64'(lat), 64'd3);
        check("lw_addr", addr_seen, 64'h1000);

        // Read-modify-write halfword store.
        do_op(1'b1, 3'd1, 1'b0, 64'h1002, 64'hBEEF);
        check("sh_rd_cycles", rd_mask, 64'h6);
        check("sh_wr_cycles", wr_mask, 64'h18);
        check("sh_wdata", wdata_seen, 64'h8877_6655_BEEF_2211);
        check("sh_lat", 64'(lat), 64'd5);
        check("sh_rdata_zero", r_rdata, 64'd0);
        ref_store(64'h1002, 1, 64'hBEEF);
        do_op(1'b0, 3'd3, 1'b0, 64'h1000, 64'h0);
        check("sh_readback", r_rdata, ref_load(64'h1000, 3, 1'b0));

        // Misaligned and illegal size.
        do_op(1'b0, 3'd2, 1'b0, 64'h1002, 64'h0);
        check("mis_err", 64'(r_err), 64'd1);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_no_mem", rd_mask | wr_mask, 64'd0);
        check("mis_rdata", r_rdata, 64'd0);
        do_op(1'b0, 3'd5, 1'b0, 64'h1000, 64'h0);
        check("ill_err", 64'(r_err), 64'd1);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_no_mem", rd_mask | wr_mask, 64'd0);

        // Doubleword store under a busy controller.
        stall = 6;
        do_op(1'b1, 3'd3, 1'b0, 64'h2000, 64'h1122_3344_5566_7788);
        check("sd_lat", 64'(lat), 64'd9);
        check("sd_wr_cycles", wr_mask, 64'h1FE);
        check("sd_wdata", wdata_seen, 64'h1122_3344_5566_7788);
        check("sd_stable", 64'(unstable), 64'd0);
        check("sd_drop", 64'(nodrop), 64'd0);
        ref_store(64'h2000, 3, 64'h1122_3344_5566_7788);
        stall = 0;
        do_op(1'b0, 3'd3, 1'b0, 64'h2000, 64'h0);
        check("sd_readback", r_rdata, 64'h1122_3344_5566_7788);

        // Error on the read half of a byte store.
        err_next = 1'b1;
        do_op(1'b1, 3'd0, 1'b0, 64'h1001, 64'hAA);
        check("err_no_write", wr_mask, 64'd0);
        check("err_flag", 64'(r_err), 64'd1);
        check("err_rdata", r_rdata, 64'd0);
        check("err_lat", 64'(lat), 64'd3);

        // Randomized mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a  = 64'h3000 + 64'($urandom_range(0, 63));
            wd = {$urandom, $urandom};
            stall = $urandom_range(0, 3);
            el = exp_lat(st, int'(sz), a, stall);
            er = (st || is_mis(a, int'(sz))) ? 64'd0 : ref_load(a, int'(sz), sg);
            do_op(st, sz, sg, a, wd);
            check("rnd_rdata", r_rdata, er);
            check("rnd_err", 64'(r_err), 64'(is_mis(a, int'(sz))));
            check("rnd_lat", 64'(lat), 64'(el));
            check("rnd_protocol", {62'd0, unstable, nodrop}, 64'd0);
            if (st && !is_mis(a, int'(sz))) ref_store(a, int'(sz), wd);
        end
        stall = 0;
        for (int i = 0; i < 8; i++)
            check("rnd_mem", phys[(64'h3000 >> 3) + 64'(i)], ref_mem[(64'h3000 >> 3) + 64'(i)]);

        // Reset while the RMW write is outstanding.
        req_valid = 1'b1; req_store = 1'b1; req_size = 3'd1; req_signed = 1'b0;
        req_addr = 64'h4002; req_wdata = 64'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_write_req) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_mid_reached_wr", 64'(seen), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_wr_drop", 64'(mem_write_req), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        seen = resp_valid;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        check("rst_mid_no_resp", 64'(seen), 64'd0);
        do_op(1'b0, 3'd3, 1'b0, 64'h1000, 64'h0);
        check("post_rst_ld", r_rdata, ref_load(64'h1000, 3, 1'b0));
        check("post_rst_lat", 64'(lat), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
